// File: rtl/dmem_bridge_if.sv
// External request/acknowledge bus between the data-memory bridge and the system fabric.
// The master drives the request side; the slave returns the one-cycle ack and read data.
interface dmem_bridge_if;
  logic        ext_req;
  logic        ext_we;
  logic [29:0] ext_addr;
  logic [3:0]  ext_mask;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  modport master (
    output ext_req,
    output ext_we,
    output ext_addr,
    output ext_mask,
    output ext_wdata,
    input  ext_ack,
    input  ext_rdata
  );

  modport slave (
    input  ext_req,
    input  ext_we,
    input  ext_addr,
    input  ext_mask,
    input  ext_wdata,
    output ext_ack,
    output ext_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Core data-port bridge: single-cycle local TCM plus a stalling request/ack external bus
// with timeout, sticky error flag and a combinational core clock-enable.
module dmem_bridge #(
  parameter int unsigned TCM_AW  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          sys_clk_en,
  output logic          core_clk_en,
  input  logic          bus_lock,
  input  logic          memory_mode,
  input  logic [29:0]   data_address,
  input  logic [3:0]    data_mask,
  input  logic [31:0]   data_out,
  output logic [31:0]   data_in,
  output logic          bus_err,
  dmem_bridge_if.master ext
);
  localparam int unsigned CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TcmDepth = 2 ** TCM_AW;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              ext_we_q;
  logic [29:0]       ext_addr_q;
  logic [3:0]        ext_mask_q;
  logic [31:0]       ext_wdata_q;
  logic [31:0]       resp_q;
  logic [31:0]       data_in_q;
  logic              bus_err_q;
  logic [31:0]       tcm_mem [TcmDepth];

  logic              tcm_hit;
  logic              ext_hit;
  logic              tcm_acc;
  logic              timeout_hit;
  logic              stall;
  logic [TCM_AW-1:0] tcm_idx;

  assign tcm_idx     = data_address[TCM_AW-1:0];
  assign tcm_hit     = (data_address[29:TCM_AW] == '0);
  assign ext_hit     = bus_lock && !tcm_hit;
  // Only IDLE accepts TCM accesses; in DONE the frozen request is the completed external one.
  assign tcm_acc     = (state_q == StIdle) && bus_lock && tcm_hit && sys_clk_en;
  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = ext_hit;
        if (ext_hit && sys_clk_en) state_d = StReq;
      end
      StReq: begin
        stall = 1'b1;
        if (ext.ext_ack || timeout_hit) state_d = StDone;
      end
      StDone: begin
        if (sys_clk_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Combinational from bus_lock/data_address so the core freezes in the decode cycle.
  assign core_clk_en = sys_clk_en && !stall;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_mask_q  <= '0;
      ext_wdata_q <= '0;
      resp_q      <= '0;
      data_in_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && (state_d == StReq)) begin
        cnt_q       <= '0;
        ext_we_q    <= memory_mode;
        ext_addr_q  <= data_address;
        ext_mask_q  <= data_mask;
        ext_wdata_q <= data_out;
      end else if (state_q == StReq) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // An ack coinciding with the timeout cycle takes priority over the error path.
      if ((state_q == StReq) && (state_d == StDone)) begin
        if (ext.ext_ack) begin
          resp_q <= ext.ext_rdata;
        end else begin
          resp_q    <= '1;
          bus_err_q <= 1'b1;
        end
      end
      if ((state_q == StDone) && sys_clk_en) begin
        data_in_q <= ext_we_q ? '0 : resp_q;
      end else if (tcm_acc) begin
        data_in_q <= memory_mode ? '0 : tcm_mem[tcm_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst && tcm_acc && memory_mode) begin
      for (int b = 0; b < 4; b++) begin
        if (data_mask[b]) tcm_mem[tcm_idx][8*b +: 8] <= data_out[8*b +: 8];
      end
    end
  end

  assign ext.ext_req   = (state_q == StReq);
  assign ext.ext_we    = ext_we_q;
  assign ext.ext_addr  = ext_addr_q;
  assign ext.ext_mask  = ext_mask_q;
  assign ext.ext_wdata = ext_wdata_q;
  assign data_in       = data_in_q;
  assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized accesses checked
// against a transaction-level model of the TCM, external slave latency and timeout rules.
module tb_dmem_bridge;
  localparam int unsigned TcmAw   = 10;
  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        sys_clk_en;
  logic        core_clk_en;
  logic        bus_lock;
  logic        memory_mode;
  logic [29:0] data_address;
  logic [3:0]  data_mask;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        bus_err;

  dmem_bridge_if bus ();

  dmem_bridge #(
    .TCM_AW  (TcmAw),
    .TIMEOUT (Timeout)
  ) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .sys_clk_en   (sys_clk_en),
    .core_clk_en  (core_clk_en),
    .bus_lock     (bus_lock),
    .memory_mode  (memory_mode),
    .data_address (data_address),
    .data_mask    (data_mask),
    .data_out     (data_out),
    .data_in      (data_in),
    .bus_err      (bus_err),
    .ext          (bus.master)
  );

  always #5 clk = ~clk;

  int          n_total;
  int          n_bad;
  int          slave_lat;
  bit          stray_ack;
  bit          err_model;
  logic [31:0] ref_tcm [1024];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [29:0] a);
    if (a == 30'h400) return 32'h1234_5678;
    return {a, 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [29:0] pool_addr(input int i);
    return (i < 16) ? 30'(i) : 30'(1023 - (i - 16));
  endfunction

  // External slave: acks on the slave_lat-th request cycle (0 = never); stray_ack pulses when idle.
  initial begin
    int cnt;
    cnt = 0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.ext_req) begin
        cnt++;
        bus.ext_ack   = (slave_lat != 0) && (cnt == slave_lat);
        bus.ext_rdata = bus.ext_ack ? rdata_of(bus.ext_addr) : $urandom;
      end else begin
        cnt           = 0;
        bus.ext_ack   = stray_ack;
        bus.ext_rdata = $urandom;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the access is accepted.
  task automatic access(input bit we, input logic [29:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd, output logic [31:0] rd, output int stalls,
                        output int reqs, output int txns);
    bit prev;
    memory_mode  = we;
    data_address = addr;
    data_mask    = mask;
    data_out     = wd;
    bus_lock     = 1'b1;
    stalls = 0;
    reqs   = 0;
    txns   = 0;
    prev   = 1'b0;
    #1;
    while (core_clk_en !== 1'b1 && stalls < 50) begin
      stalls++;
      if (bus.ext_req) begin
        reqs++;
        if (!prev) txns++;
        check_eq("ext_ctl", 64'({bus.ext_we, bus.ext_mask, bus.ext_addr}), 64'({we, mask, addr}));
        check_eq("ext_wdata", 64'(bus.ext_wdata), 64'(wd));
      end
      prev = bus.ext_req;
      @(negedge clk);
      #1;
    end
    check_eq("accept", 64'(core_clk_en), 64'(1));
    check_eq("req_at_accept", 64'(bus.ext_req), 64'(0));
    @(negedge clk);
    bus_lock = 1'b0;
    rd = data_in;
  endtask

  task automatic run_and_check(input bit we, input logic [29:0] addr, input logic [3:0] mask,
                               input logic [31:0] wd, input int lat);
    logic [31:0] exp_data, rd;
    int exp_stalls, exp_reqs, exp_txns, stalls, reqs, txns, eff;
    bit timed;
    if (addr[29:TcmAw] == '0) begin
      exp_stalls = 0;
      exp_reqs   = 0;
      exp_txns   = 0;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_tcm[addr[TcmAw-1:0]][8*b +: 8] = wd[8*b +: 8];
        exp_data = '0;
      end else begin
        exp_data = ref_tcm[addr[TcmAw-1:0]];
      end
    end else begin
      timed      = (lat == 0) || (lat > int'(Timeout));
      eff        = timed ? int'(Timeout) : lat;
      exp_stalls = 1 + eff;
      exp_reqs   = eff;
      exp_txns   = 1;
      exp_data   = we ? 32'h0 : (timed ? 32'hFFFF_FFFF : rdata_of(addr));
      if (timed) err_model = 1'b1;
    end
    slave_lat = lat;
    access(we, addr, mask, wd, rd, stalls, reqs, txns);
    check_eq("data_in", 64'(rd), 64'(exp_data));
    check_eq("stall_cycles", 64'(stalls), 64'(exp_stalls));
    check_eq("req_cycles", 64'(reqs), 64'(exp_reqs));
    check_eq("txn_count", 64'(txns), 64'(exp_txns));
    check_eq("bus_err", 64'(bus_err), 64'(err_model));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind, lat;
    logic [29:0] a;
    logic [19:0] hi;
    n_total = 0; n_bad = 0; slave_lat = 0; stray_ack = 1'b0; err_model = 1'b0;
    sync_rst = 1'b1; sys_clk_en = 1'b1; bus_lock = 1'b0; memory_mode = 1'b0;
    data_address = '0; data_mask = '0; data_out = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ext_req", 64'(bus.ext_req), 64'(0));
    check_eq("rst_ext_ctl", 64'({bus.ext_we, bus.ext_mask, bus.ext_addr}), 64'(0));
    check_eq("rst_ext_wdata", 64'(bus.ext_wdata), 64'(0));
    check_eq("rst_data_in", 64'(data_in), 64'(0));
    check_eq("rst_bus_err", 64'(bus_err), 64'(0));
    check_eq("rst_clk_en", 64'(core_clk_en), 64'(1));
    sync_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 32; i++) run_and_check(1'b1, pool_addr(i), 4'hF, $urandom, 0);

    // TCM byte merge, external read/write, ack exactly at the timeout cycle
    run_and_check(1'b1, 30'h005, 4'b1111, 32'hDEAD_BEEF, 0);
    run_and_check(1'b1, 30'h005, 4'b0001, 32'h0000_00AA, 0);
    run_and_check(1'b0, 30'h005, 4'b1111, 32'h0, 0);
    run_and_check(1'b0, 30'h400, 4'b1111, 32'h0, 3);
    run_and_check(1'b1, 30'h800, 4'b0110, 32'hCAFE_F00D, 2);
    run_and_check(1'b0, 30'h0001_2345, 4'b1111, 32'h0, int'(Timeout));

    // Stray ack while idle must change nothing
    #2 stray_ack = 1'b1;
    @(negedge clk);
    #2 stray_ack = 1'b0;
    @(negedge clk);
    #1;
    check_eq("stray_req", 64'(bus.ext_req), 64'(0));
    check_eq("stray_clk_en", 64'(core_clk_en), 64'(1));
    check_eq("stray_data", 64'(data_in), 64'(rdata_of(30'h0001_2345)));
    @(negedge clk);

    // sys_clk_en low in DONE holds the completion
    slave_lat = 1;
    memory_mode = 1'b0; data_address = 30'h0004_0010; data_mask = 4'hF; data_out = '0;
    bus_lock = 1'b1;
    #1 check_eq("hold_idle_stall", 64'(core_clk_en), 64'(0));
    @(negedge clk);
    #1 check_eq("hold_req", 64'(bus.ext_req), 64'(1));
    @(negedge clk);
    sys_clk_en = 1'b0;
    #1 check_eq("hold_gated", 64'(core_clk_en), 64'(0));
    @(negedge clk);
    sys_clk_en = 1'b1;
    #1 check_eq("hold_done", 64'(core_clk_en), 64'(1));
    check_eq("hold_no_reissue", 64'(bus.ext_req), 64'(0));
    @(negedge clk);
    bus_lock = 1'b0;
    check_eq("hold_data", 64'(data_in), 64'(rdata_of(30'h0004_0010)));
    #1 check_eq("hold_req_after", 64'(bus.ext_req), 64'(0));
    @(negedge clk);

    // Timeouts (read and write) make bus_err sticky across a later acked access
    run_and_check(1'b0, 30'h0002_0000, 4'hF, 32'h0, 0);
    run_and_check(1'b0, 30'h0003_0001, 4'hF, 32'h0, 2);
    run_and_check(1'b1, 30'h0003_0002, 4'b1010, 32'h1357_9BDF, 6);

    // Reset in the middle of an external request
    slave_lat = 0;
    memory_mode = 1'b0; data_address = 30'h0001_0005; data_mask = 4'hF; data_out = '0;
    bus_lock = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("mid_req", 64'(bus.ext_req), 64'(1));
    @(negedge clk);
    sync_rst = 1'b1;
    bus_lock = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_req_drop", 64'(bus.ext_req), 64'(0));
    check_eq("rst_req_data", 64'(data_in), 64'(0));
    check_eq("rst_req_clk_en", 64'(core_clk_en), 64'(1));
    check_eq("rst_req_err", 64'(bus_err), 64'(0));
    sync_rst  = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("rst_no_completion", 64'(data_in), 64'(0));
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(0, 6));
      hi   = 20'($urandom_range(1, 20'hF_FFFF));
      if (kind < 2) a = pool_addr(int'($urandom_range(0, 31)));
      else          a = {hi, 10'($urandom)};
      run_and_check(kind == 0 || kind == 3, a, 4'($urandom), $urandom, lat);
      if ($urandom_range(0, 7) == 0) begin
        sys_clk_en = 1'b0;
        #1 check_eq("sys_gate", 64'(core_clk_en), 64'(0));
        @(negedge clk);
        sys_clk_en = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
